// File: rtl/arbiter_round_robin_hold.sv
// arbiter_round_robin_hold
// N-requester round-robin arbiter with grant hold. The owner keeps its grant
// while it holds req; on release the grant hands off directly to the next
// pending requester after the owner, or the arbiter returns to idle.
// Optional timeout preemption is built when ARB_RR_MAX_HOLD_EN is defined;
// without it, preempt is tied low and a grant is held indefinitely.
module arbiter_round_robin_hold #(
   parameter int WIDTH    = 32,
   parameter int GID_W    = $clog2(WIDTH),
   parameter int MAX_HOLD = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] grt,
   output logic [GID_W-1:0] gid,
   output logic             busy,
   output logic             preempt
);

   typedef enum logic {IDLE, OWN} state_e;

   localparam logic [GID_W-1:0] LAST_RST = GID_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] grt_q, grt_d;
   logic [GID_W-1:0] gid_q, gid_d;
   logic             busy_q, busy_d;
   logic [GID_W-1:0] last_q, last_d;

   // Search result: {found, index}
   logic [GID_W:0]   idle_pick;
   logic [GID_W:0]   hand_pick;
   logic             take;
   logic [GID_W-1:0] take_idx;
   logic             owner_holds;

`ifdef ARB_RR_MAX_HOLD_EN
   localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD - 1);
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic        preempt_q, preempt_d;
`else
   logic        unused_max_hold;
   assign unused_max_hold = ^MAX_HOLD;
`endif

   // First set bit of r searching base+1, base+2, ... modulo WIDTH.
   // Iterating downward lets the closest hit overwrite farther ones.
   function automatic logic [GID_W:0] rr_pick(input logic [WIDTH-1:0] r,
                                              input logic [GID_W-1:0] base);
      logic             found;
      logic [GID_W-1:0] idx;
      logic [WIDTH-1:0] sh;
      int               pos;
      found = 1'b0;
      idx   = '0;
      for (int k = WIDTH; k >= 1; k--) begin
         pos = (int'(base) + k) % WIDTH;
         sh  = r >> pos;
         if (sh[0]) begin
            found = 1'b1;
            idx   = GID_W'(pos);
         end
      end
      return {found, idx};
   endfunction

   // In OWN, last_q equals gid_q; masking the owner out makes the same search
   // serve both a release (owner bit already low) and a timeout handoff.
   assign idle_pick   = rr_pick(req, last_q);
   assign hand_pick   = rr_pick(req & ~grt_q, gid_q);
   assign owner_holds = |(req & grt_q);

   // Next-state and next-grant selection
   always_comb begin
      state_d  = state_q;
      grt_d    = grt_q;
      gid_d    = gid_q;
      busy_d   = busy_q;
      last_d   = last_q;
      take     = 1'b0;
      take_idx = '0;
`ifdef ARB_RR_MAX_HOLD_EN
      hold_cnt_d = hold_cnt_q;
      preempt_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (idle_pick[GID_W]) begin
               take     = 1'b1;
               take_idx = idle_pick[GID_W-1:0];
            end
         end
         OWN: begin
            if (!owner_holds) begin
               if (hand_pick[GID_W]) begin
                  take     = 1'b1;
                  take_idx = hand_pick[GID_W-1:0];
               end else begin
                  state_d = IDLE;
                  grt_d   = '0;
                  gid_d   = '0;
                  busy_d  = 1'b0;
               end
            end
`ifdef ARB_RR_MAX_HOLD_EN
            else if (hold_cnt_q == HOLD_LIM && hand_pick[GID_W]) begin
               take      = 1'b1;
               take_idx  = hand_pick[GID_W-1:0];
               preempt_d = 1'b1;
            end else if (hold_cnt_q != HOLD_LIM) begin
               hold_cnt_d = hold_cnt_q + 16'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (take) begin
         state_d = OWN;
         grt_d   = {{(WIDTH-1){1'b0}}, 1'b1} << take_idx;
         gid_d   = take_idx;
         busy_d  = 1'b1;
         last_d  = take_idx;
`ifdef ARB_RR_MAX_HOLD_EN
         hold_cnt_d = '0;
`endif
      end
   end

   // State and registered outputs; reset drops any grant immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grt_q   <= '0;
         gid_q   <= '0;
         busy_q  <= 1'b0;
         last_q  <= LAST_RST;
`ifdef ARB_RR_MAX_HOLD_EN
         hold_cnt_q <= '0;
         preempt_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grt_q   <= grt_d;
         gid_q   <= gid_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
`ifdef ARB_RR_MAX_HOLD_EN
         hold_cnt_q <= hold_cnt_d;
         preempt_q  <= preempt_d;
`endif
      end
   end

   assign grt  = grt_q;
   assign gid  = gid_q;
   assign busy = busy_q;
`ifdef ARB_RR_MAX_HOLD_EN
   assign preempt = preempt_q;
`else
   assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_round_robin_hold.sv
// Bench for arbiter_round_robin_hold: directed steps plus a randomized
// requester run, checked against a tenure-level reference model.
module tb_arbiter_round_robin_hold;

   localparam int W    = 32;
   localparam int MAXH = 8;
`ifdef ARB_RR_MAX_HOLD_EN
   localparam bit PRE_EN = 1'b1;
`else
   localparam bit PRE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  req;
   logic [W-1:0]  grt;
   logic [4:0]    gid;
   logic          busy;
   logic          preempt;

   int tests = 0;
   int fails = 0;

   // Reference model: current owner (-1 = none), last owner, cycles owned
   int m_own  = -1;
   int m_last = W - 1;
   int m_ten  = 0;
   bit m_pre  = 1'b0;

   arbiter_round_robin_hold #(.WIDTH(W), .GID_W(5), .MAX_HOLD(MAXH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .grt     (grt),
      .gid     (gid),
      .busy    (busy),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // First requester in r at or after position 'from' (circular), excluding 'skip'
   function automatic int rr_first(input logic [W-1:0] r, input int from, input int skip);
      for (int k = 0; k < W; k++) begin
         int idx;
         idx = (from + k) % W;
         if (r[idx[4:0]] && idx != skip) return idx;
      end
      return -1;
   endfunction

   task automatic model_update(input logic [W-1:0] r);
      int n;
      m_pre = 1'b0;
      if (m_own < 0) begin
         n = rr_first(r, m_last + 1, -1);
         if (n >= 0) begin m_own = n; m_last = n; m_ten = 1; end
      end else if (!r[m_own[4:0]]) begin
         n = rr_first(r, m_own + 1, -1);
         if (n >= 0) begin m_own = n; m_last = n; m_ten = 1; end
         else m_own = -1;
      end else begin
         n = rr_first(r, m_own + 1, m_own);
         if (PRE_EN && m_ten >= MAXH && n >= 0) begin
            m_own = n; m_last = n; m_ten = 1; m_pre = 1'b1;
         end else begin
            m_ten++;
         end
      end
   endtask

   task automatic step(input logic [W-1:0] r);
      logic [W-1:0] eg;
      req = r;
      @(posedge clk);
      model_update(r);
      #1;
      eg = (m_own < 0) ? '0 : (32'h1 << m_own);
      check("grt", grt, eg);
      check("gid", 32'(gid), (m_own < 0) ? 32'd0 : 32'(m_own));
      check("busy", 32'(busy), 32'(m_own >= 0));
      check("preempt", 32'(preempt), 32'(m_pre));
      check("onehot0", 32'($onehot0(grt)), 32'd1);
      check("grt_without_req", grt & ~r, 32'd0);
   endtask

   // Asynchronous reset: outputs must clear with no clock edge in between
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_grt", grt, 32'd0);
      check("rst_gid", 32'(gid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_preempt", 32'(preempt), 32'd0);
      m_own = -1; m_last = W - 1; m_ten = 0; m_pre = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   int           hold_left [W];
   bit           active    [W];
   int           wait_cnt  [W];
   int           gcount    [W];
   logic [W-1:0] prev_grt;
   logic [W-1:0] r;
   bit           tstart;

   initial begin
      rst_n = 1'b1;
      req   = '0;
      #2;
      do_reset();

      // Single requester: grant one cycle later, release one cycle after drop
      step(32'h1);
      check("single_grt", grt, 32'h1);
      step(32'h0);
      check("single_release", grt, 32'h0);

      // All requesting, each owner releases after 3 cycles: 0,1,...,31,0
      do_reset();
      step('1);
      check("rr_first", grt, 32'h1);
      for (int k = 0; k < W; k++) begin
         step('1);
         step('1);
         step('1 & ~(32'h1 << k));
         check("rr_order", 32'(gid), 32'((k + 1) % W));
      end

      // Wrap-around: last=31, bits 5 and 0 together -> 0 then 5
      do_reset();
      step(32'h21);
      check("wrap_first", grt, 32'h1);
      step(32'h21);
      step(32'h20);
      check("wrap_second", grt, 32'h20);

      // Direct handoff 3 -> 7 with no idle cycle
      do_reset();
      step(32'h8);
      for (int k = 0; k < 3; k++) step(32'h88);
      check("hold_owner3", grt, 32'h8);
      step(32'h80);
      check("handoff_7", grt, 32'h80);

      // Reset mid-grant, then search restarts at index 0 (not after 7)
      do_reset();
      step(32'h201);
      check("restart0", grt, 32'h1);

      // Owner 2 holding while 4 is pending
      do_reset();
      step(32'h4);
      for (int k = 0; k < 7; k++) step(32'h14);
      check("hold_7cyc", grt, 32'h4);
      step(32'h14);
`ifdef ARB_RR_MAX_HOLD_EN
      check("preempt_grt", grt, 32'h10);
      check("preempt_pulse", 32'(preempt), 32'd1);
      step(32'h14);
      check("preempt_drop", 32'(preempt), 32'd0);
`else
      check("no_preempt_grt", grt, 32'h4);
      check("no_preempt_pulse", 32'(preempt), 32'd0);
`endif
      for (int k = 0; k < 20; k++) step(32'h14);

      // Lone requester never preempted
      do_reset();
      for (int k = 0; k < 100; k++) step(32'h4);
      check("lone_hold", grt, 32'h4);

      // Randomized stimulus_one-style requesters
      do_reset();
      for (int i = 0; i < W; i++) begin
         hold_left[i] = 0; active[i] = 1'b0; wait_cnt[i] = 0; gcount[i] = 0;
      end
      prev_grt = '0;
      for (int c = 0; c < 5000; c++) begin
         for (int i = 0; i < W; i++) begin
            if (!active[i]) begin
               if ($urandom_range(7) == 0) begin
                  active[i]    = 1'b1;
                  hold_left[i] = $urandom_range(4, 1);
               end
            end else if (grt[i]) begin
               hold_left[i]--;
               if (hold_left[i] == 0) active[i] = 1'b0;
            end
            r[i] = active[i];
         end
         step(r);
         tstart = (grt != '0) && (grt != prev_grt);
         if (tstart) gcount[gid]++;
         for (int i = 0; i < W; i++) begin
            if (!r[i] || grt[i]) begin
               wait_cnt[i] = 0;
            end else if (tstart) begin
               wait_cnt[i]++;
               check("fairness", 32'(wait_cnt[i] <= W - 1), 32'd1);
            end
         end
         prev_grt = grt;
      end
      for (int i = 0; i < W; i++) check("grant_count", 32'(gcount[i] > 0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
